// File: rtl/st_pkt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : st_pkt_pkg
//  Brief    : Shared constants, FSM encoding and framing helper for the
//             256-bit Avalon-ST packet source.
//  Revision : 1.0
// ============================================================================
package st_pkt_pkg;

    localparam int WORD_W     = 32;
    localparam int BEAT_WORDS = 8;
    localparam int BEAT_W     = WORD_W * BEAT_WORDS;
    localparam int EMPTY_W    = $clog2(BEAT_W / 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Bytes left unused in the eop beat, given how many words it carries.
    function automatic int empty_bytes(
        input int words_in_last,
        input int beat_words = BEAT_WORDS,
        input int word_bytes = WORD_W / 8
    );
        return (beat_words - words_in_last) * word_bytes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/st_out_reg.sv
`default_nettype none
// ============================================================================
//  Module   : st_out_reg
//  Brief    : One-entry Avalon-ST holding register (data, sop, eop, empty).
//  Revision : 1.0
// ============================================================================
module st_out_reg
    import st_pkt_pkg::*;
#(
    parameter int DATA_W      = BEAT_W,
    parameter int OUT_EMPTY_W = EMPTY_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_load,
    input  logic [DATA_W-1:0]      i_data,
    input  logic                   i_sop,
    input  logic                   i_eop,
    input  logic [OUT_EMPTY_W-1:0] i_empty,
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic [DATA_W-1:0]      o_data,
    output logic                   o_sop,
    output logic                   o_eop,
    output logic [OUT_EMPTY_W-1:0] o_empty,
    output logic                   o_slot_free
);

    logic                   r_valid;
    logic [DATA_W-1:0]      r_data;
    logic                   r_sop;
    logic                   r_eop;
    logic [OUT_EMPTY_W-1:0] r_empty;

    // Contents only change on a load, so a stalled beat stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_empty <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_sop   <= i_sop;
            r_eop   <= i_eop;
            r_empty <= i_empty;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_slot_free = !r_valid || i_ready;
    assign o_valid     = r_valid;
    assign o_data      = r_data;
    assign o_sop       = r_sop;
    assign o_eop       = r_eop;
    assign o_empty     = r_empty;

endmodule
`default_nettype wire

// File: rtl/st_pkt_source_256.sv
`default_nettype none
// ============================================================================
//  Module   : st_pkt_source_256
//  Brief    : Packs a word stream into framed 256-bit Avalon-ST beats.
//  Revision : 1.0
// ============================================================================
module st_pkt_source_256 #(
    parameter int WORD_W     = 32,
    parameter int BEAT_WORDS = 8,
    parameter int LEN_W      = 16
) (
    input  logic                                      clk_clk,
    input  logic                                      reset_reset,
    input  logic [LEN_W-1:0]                          cfg_len_words,
    input  logic                                      cfg_start,
    output logic                                      busy,
    output logic                                      pkt_done,
    output logic [31:0]                               pkt_count,
    input  logic [WORD_W-1:0]                         in_data,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    output logic [WORD_W*BEAT_WORDS-1:0]              out_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic                                      out_startofpacket,
    output logic                                      out_endofpacket,
    output logic [$clog2(WORD_W*BEAT_WORDS/8)-1:0]    out_empty
);
    import st_pkt_pkg::*;

    localparam int c_BEAT_W  = WORD_W * BEAT_WORDS;
    localparam int c_EMPTY_W = $clog2(c_BEAT_W / 8);
    localparam int c_LANE_W  = (BEAT_WORDS > 1) ? $clog2(BEAT_WORDS) : 1;

    state_e                r_state;
    logic [LEN_W-1:0]      r_words_left;
    logic [c_LANE_W-1:0]   r_lane;
    logic                  r_first_beat;
    logic [c_BEAT_W-1:0]   r_pack;
    logic                  r_pkt_done;
    logic [31:0]           r_pkt_count;

    logic                  w_last_word;
    logic                  w_closing;
    logic                  w_slot_free;
    logic                  w_accept;
    logic                  w_load;
    logic                  w_eop_hs;
    logic [c_BEAT_W-1:0]   w_beat;
    logic [c_EMPTY_W-1:0]  w_empty;

    assign w_last_word = (r_words_left == LEN_W'(1));
    assign w_closing   = (r_lane == c_LANE_W'(BEAT_WORDS - 1)) || w_last_word;
    assign in_ready    = (r_state == FILL) && (!w_closing || w_slot_free);
    assign w_accept    = in_valid && in_ready;
    assign w_load      = w_accept && w_closing;
    assign w_eop_hs    = out_valid && out_ready && out_endofpacket;

    // Pack register with the incoming word dropped into the current lane.
    for (genvar k = 0; k < BEAT_WORDS; k++) begin : g_lane
        assign w_beat[k*WORD_W +: WORD_W] =
            (r_lane == c_LANE_W'(k)) ? in_data : r_pack[k*WORD_W +: WORD_W];
    end

    assign w_empty = w_last_word
                   ? c_EMPTY_W'(empty_bytes(int'(r_lane) + 1, BEAT_WORDS, WORD_W / 8))
                   : '0;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state      <= IDLE;
            r_words_left <= '0;
            r_lane       <= '0;
            r_first_beat <= 1'b0;
            r_pack       <= '0;
            r_pkt_done   <= 1'b0;
            r_pkt_count  <= '0;
        end else begin
            r_pkt_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cfg_start && (cfg_len_words != '0)) begin
                        r_words_left <= cfg_len_words;
                        r_lane       <= '0;
                        r_first_beat <= 1'b1;
                        r_pack       <= '0;
                        r_state      <= FILL;
                    end
                end
                FILL: begin
                    if (w_accept) begin
                        r_words_left <= r_words_left - LEN_W'(1);
                        if (w_closing) begin
                            r_pack       <= '0;
                            r_lane       <= '0;
                            r_first_beat <= 1'b0;
                        end else begin
                            r_pack <= w_beat;
                            r_lane <= r_lane + c_LANE_W'(1);
                        end
                        if (w_last_word) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_eop_hs) begin
                        r_state     <= IDLE;
                        r_pkt_done  <= 1'b1;
                        r_pkt_count <= r_pkt_count + 32'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    st_out_reg #(
        .DATA_W      (c_BEAT_W),
        .OUT_EMPTY_W (c_EMPTY_W)
    ) u_out_reg (
        .clk         (clk_clk),
        .rst         (reset_reset),
        .i_load      (w_load),
        .i_data      (w_beat),
        .i_sop       (r_first_beat),
        .i_eop       (w_last_word),
        .i_empty     (w_empty),
        .i_ready     (out_ready),
        .o_valid     (out_valid),
        .o_data      (out_data),
        .o_sop       (out_startofpacket),
        .o_eop       (out_endofpacket),
        .o_empty     (out_empty),
        .o_slot_free (w_slot_free)
    );

    assign busy      = (r_state != IDLE);
    assign pkt_done  = r_pkt_done;
    assign pkt_count = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_st_pkt_source_256.sv
`default_nettype none
// ============================================================================
//  Module   : tb_st_pkt_source_256
//  Brief    : Directed scoreboard bench for the 256-bit Avalon-ST packet source.
//  Revision : 1.0
// ============================================================================
module tb_st_pkt_source_256;

    typedef struct packed {
        logic [255:0] data;
        logic         sop;
        logic         eop;
        logic [4:0]   empty;
    } beat_t;

    logic         clk;
    logic         reset_reset;
    logic [15:0]  cfg_len_words;
    logic         cfg_start;
    logic         busy;
    logic         pkt_done;
    logic [31:0]  pkt_count;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_startofpacket;
    logic         out_endofpacket;
    logic [4:0]   out_empty;

    int    checks = 0;
    int    errors = 0;
    beat_t q[$];
    beat_t cur;
    beat_t held;
    beat_t exp_b;
    bit    held_valid = 0;
    bit    exp_done   = 0;

    st_pkt_source_256 dut (
        .clk_clk           (clk),
        .reset_reset       (reset_reset),
        .cfg_len_words     (cfg_len_words),
        .cfg_start         (cfg_start),
        .busy              (busy),
        .pkt_done          (pkt_done),
        .pkt_count         (pkt_count),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_empty         (out_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected beats of a packet whose word i carries value base+i.
    task automatic push_pkt(input int len, input int base);
        beat_t b;
        int nb;
        nb = (len + 7) / 8;
        for (int bi = 0; bi < nb; bi++) begin
            int nw;
            nw = (len - bi * 8 > 8) ? 8 : len - bi * 8;
            b.data = '0;
            for (int k = 0; k < nw; k++) b.data[k*32 +: 32] = 32'(base + bi * 8 + k);
            b.sop   = (bi == 0);
            b.eop   = (bi == nb - 1);
            b.empty = b.eop ? 5'(4 * (8 - nw)) : 5'd0;
            q.push_back(b);
        end
    endtask

    task automatic start_pkt(input int len);
        cfg_len_words = 16'(len);
        cfg_start     = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        checks++;
        assert (busy === 1'b1 && in_ready === 1'b1) else begin
            errors++;
            $error("FAIL start_busy: observed busy=%b in_ready=%b expected 1 1", busy, in_ready);
        end
    endtask

    task automatic drive_words(input int n, input int base, input int max_cycles);
        int  i;
        int  c;
        bit  acc;
        i = 0;
        c = 0;
        while (i < n && c < max_cycles) begin
            in_valid = 1'b1;
            in_data  = 32'(base + i);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            c++;
        end
        in_valid = 1'b0;
        checks++;
        assert (i == n) else begin
            errors++;
            $error("FAIL drive_timeout: observed %0d words accepted expected %0d", i, n);
        end
    endtask

    task automatic wait_done(input int max_cycles, input int exp_count);
        int c;
        bit seen;
        c    = 0;
        seen = 1'b0;
        while (!seen && c < max_cycles) begin
            @(posedge clk); #1;
            seen = pkt_done;
            c++;
        end
        checks++;
        assert (seen == 1'b1) else begin
            errors++;
            $error("FAIL done_timeout: observed no pkt_done expected pkt_done within %0d cycles", max_cycles);
        end
        checks++;
        assert (busy === 1'b0 && pkt_count === 32'(exp_count)) else begin
            errors++;
            $error("FAIL pkt_count: observed busy=%b count=%0d expected busy=0 count=%0d", busy, pkt_count, exp_count);
        end
    endtask

    // Output monitor: scoreboard pop, Avalon-ST hold stability and pkt_done timing.
    always @(negedge clk) begin
        cur = '{data: out_data, sop: out_startofpacket, eop: out_endofpacket, empty: out_empty};
        if (reset_reset) begin
            exp_done   = 1'b0;
            held_valid = 1'b0;
        end else begin
            checks++;
            assert (pkt_done === exp_done) else begin
                errors++;
                $error("FAIL pkt_done: observed %b expected %b", pkt_done, exp_done);
            end
            if (held_valid) begin
                checks++;
                assert (out_valid === 1'b1 && cur === held) else begin
                    errors++;
                    $error("FAIL hold_stable: observed valid=%b beat=%h expected valid=1 beat=%h", out_valid, cur, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                assert (q.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_beat: observed beat %h expected none", cur);
                end
                if (q.size() > 0) begin
                    exp_b = q.pop_front();
                    checks++;
                    assert (cur.data === exp_b.data) else begin
                        errors++;
                        $error("FAIL beat_data: observed %h expected %h", cur.data, exp_b.data);
                    end
                    checks++;
                    assert ({cur.sop, cur.eop, cur.empty} === {exp_b.sop, exp_b.eop, exp_b.empty}) else begin
                        errors++;
                        $error("FAIL beat_framing: observed sop=%b eop=%b empty=%0d expected sop=%b eop=%b empty=%0d",
                               cur.sop, cur.eop, cur.empty, exp_b.sop, exp_b.eop, exp_b.empty);
                    end
                end
            end
            exp_done   = out_valid && out_ready && out_endofpacket;
            held_valid = out_valid && !out_ready;
            held       = cur;
        end
    end

    initial begin
        reset_reset   = 1'b1;
        cfg_len_words = '0;
        cfg_start     = 1'b0;
        in_data       = '0;
        in_valid      = 1'b0;
        out_ready     = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checks++;
        assert ({out_valid, out_startofpacket, out_endofpacket, busy, pkt_done, in_ready} === 6'b0) else begin
            errors++;
            $error("FAIL reset_flags: observed %b expected 000000",
                   {out_valid, out_startofpacket, out_endofpacket, busy, pkt_done, in_ready});
        end
        checks++;
        assert (out_data === 256'd0 && out_empty === 5'd0 && pkt_count === 32'd0) else begin
            errors++;
            $error("FAIL reset_values: observed data=%h empty=%0d count=%0d expected 0 0 0", out_data, out_empty, pkt_count);
        end
        reset_reset = 1'b0;
        @(posedge clk); #1;

        // Full single beat
        push_pkt(8, 0);
        start_pkt(8);
        drive_words(8, 0, 100);
        wait_done(20, 1);

        // Two beats, partial eop beat
        push_pkt(11, 0);
        start_pkt(11);
        drive_words(11, 0, 100);
        wait_done(20, 2);

        // Back-pressure: sink stalled, then released
        push_pkt(24, 100);
        start_pkt(24);
        out_ready = 1'b0;
        fork
            drive_words(24, 100, 200);
            begin
                repeat (18) @(posedge clk);
                #2;
                checks++;
                assert ({in_valid, in_ready, in_data} === {1'b1, 1'b0, 32'd115}) else begin
                    errors++;
                    $error("FAIL stall_in_ready: observed valid=%b ready=%b data=%0d expected 1 0 115",
                           in_valid, in_ready, in_data);
                end
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_done(20, 3);

        // Single-word packet
        push_pkt(1, 500);
        start_pkt(1);
        drive_words(1, 500, 20);
        wait_done(20, 4);

        // Zero-length start ignored
        cfg_len_words = 16'd0;
        cfg_start     = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        checks++;
        assert (busy === 1'b0 && in_ready === 1'b0) else begin
            errors++;
            $error("FAIL zero_len_start: observed busy=%b in_ready=%b expected 0 0", busy, in_ready);
        end

        // Start and length change while busy ignored
        push_pkt(8, 600);
        start_pkt(8);
        drive_words(3, 600, 20);
        cfg_len_words = 16'd3;
        cfg_start     = 1'b1;
        @(posedge clk); #1;
        cfg_start     = 1'b0;
        cfg_len_words = 16'd5;
        checks++;
        assert (busy === 1'b1) else begin
            errors++;
            $error("FAIL busy_restart: observed busy=%b expected 1", busy);
        end
        drive_words(5, 603, 20);
        wait_done(20, 5);

        // Reset mid-packet abandons it
        start_pkt(16);
        drive_words(5, 700, 20);
        reset_reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        assert ({out_valid, busy, in_ready} === 3'b000 && pkt_count === 32'd0) else begin
            errors++;
            $error("FAIL mid_reset: observed valid=%b busy=%b ready=%b count=%0d expected 0 0 0 0",
                   out_valid, busy, in_ready, pkt_count);
        end
        reset_reset = 1'b0;
        @(posedge clk); #1;
        push_pkt(8, 800);
        start_pkt(8);
        drive_words(8, 800, 100);
        wait_done(20, 1);

        repeat (2) @(posedge clk);
        #1;
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d beats outstanding expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
